// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage memories: access-size codes plus
// byte-lane helpers used by the data RAM.
package mem_pkg;

  typedef logic [1:0] mem_size_t;

  localparam mem_size_t MEM_NONE = 2'b00;
  localparam mem_size_t MEM_BYTE = 2'b01;
  localparam mem_size_t MEM_HALF = 2'b10;
  localparam mem_size_t MEM_WORD = 2'b11;

  // Lanes touched by an access, lane 0 being the byte at the access address.
  function automatic logic [3:0] lane_mask(input mem_size_t size);
    logic [3:0] m;
    case (size)
      MEM_WORD: m = 4'b1111;
      MEM_HALF: m = 4'b0011;
      MEM_BYTE: m = 4'b0001;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

  // The sign flag only matters for sub-word sizes; a word returns raw untouched.
  function automatic logic [31:0] mem_extend(input logic [31:0] raw,
                                             input mem_size_t size,
                                             input logic sign);
    logic [31:0] r;
    case (size)
      MEM_WORD: r = raw;
      MEM_HALF: r = {{16{sign & raw[15]}}, raw[15:0]};
      MEM_BYTE: r = {{24{sign & raw[7]}}, raw[7:0]};
      default:  r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// Word-fetch instruction ROM for the IF stage. Purely combinational; the
// word index wraps, and the byte offset within a word is ignored.
module instruction_memory #(
  parameter int                        IMEM_WORDS = 256,
  parameter string                     IMEM_FILE  = "",
  parameter logic [IMEM_WORDS*32-1:0]  IMEM_INIT  = '0
) (
  input  logic [31:0] addr,
  output logic [31:0] dout
);

  localparam int IW = $clog2(IMEM_WORDS);

  logic [31:0]   rom [IMEM_WORDS];
  logic [IW-1:0] idx;
  logic          unused_addr;

  always_comb begin
    for (int i = 0; i < IMEM_WORDS; i++) rom[i] = IMEM_INIT[i*32 +: 32];
  end

  assign idx         = addr[IW+1:2];
  assign dout        = rom[idx];
  assign unused_addr = ^{addr[31:IW+2], addr[1:0]};

endmodule

// File: rtl/data_memory.sv
// Byte-addressed little-endian data RAM: per-lane write enables on a
// wrapping byte address, and a combinational byte-gather/extend read path.
module data_memory
  import mem_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic        memWrite,
  input  logic        memRead,
  input  logic [1:0]  memSize,
  input  logic        memSign,
  output logic [31:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] lane_addr [4];
  logic [3:0]    lane_we;
  logic [31:0]   raw;
  logic          unused_addr;

  // Lane addresses are computed in AW bits so the top of the array wraps to 0.
  always_comb begin
    for (int i = 0; i < 4; i++) lane_addr[i] = addr[AW-1:0] + AW'(i);
  end

  assign lane_we     = memWrite ? lane_mask(memSize) : 4'b0000;
  assign unused_addr = ^addr[31:AW];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < DEPTH; j++) mem[j] <= 8'h00;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (lane_we[i]) mem[lane_addr[i]] <= din[8*i +: 8];
      end
    end
  end

  assign raw  = {mem[lane_addr[3]], mem[lane_addr[2]],
                 mem[lane_addr[1]], mem[lane_addr[0]]};
  assign dout = memRead ? mem_extend(raw, memSize, memSign) : 32'h0;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory and the companion instruction_memory.
module tb_data_memory;
  import mem_pkg::*;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, din, dout;
  logic        memWrite, memRead, memSign;
  logic [1:0]  memSize;
  logic [31:0] iaddr, idout;

  int checks   = 0;
  int failures = 0;

  data_memory #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .addr(addr), .din(din),
    .memWrite(memWrite), .memRead(memRead), .memSize(memSize),
    .memSign(memSign), .dout(dout)
  );

  instruction_memory #(
    .IMEM_WORDS(256), .IMEM_FILE(""),
    .IMEM_INIT({{254{32'h0}}, 32'h20090007, 32'h20080005})
  ) u_imem (
    .addr(iaddr), .dout(idout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [1:0]  size;
    logic        sign;
    logic        rd;
    logic [31:0] exp;
  } load_vec_t;

  load_vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] size);
    @(negedge clk);
    addr = a; din = d; memSize = size; memWrite = 1'b1; memRead = 1'b0; memSign = 1'b0;
    @(posedge clk);
    #1 memWrite = 1'b0;
  endtask

  task automatic load_check(input string name, input logic [31:0] a, input logic [1:0] size,
                            input logic sign, input logic rd, input logic [31:0] exp);
    @(negedge clk);
    addr = a; memSize = size; memSign = sign; memRead = rd; memWrite = 1'b0;
    #1 check(name, dout, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; addr = '0; din = '0; memWrite = 1'b0; memRead = 1'b0;
    memSize = MEM_NONE; memSign = 1'b0; iaddr = '0;

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    load_check("reset_lw0", 32'd0, MEM_WORD, 1'b0, 1'b1, 32'h0);
    load_check("reset_lw_top", DEPTH - 4, MEM_WORD, 1'b0, 1'b1, 32'h0);

    store(32'd0, 32'h12345678, MEM_WORD);
    store(32'd4, 32'h12345678, MEM_HALF);
    store(32'd6, 32'hFFFFFFFF, MEM_BYTE);
    store(32'd0, 32'hDEADBEEF, MEM_NONE);

    // mem[0..7] = 78 56 34 12 78 56 FF 00
    vecs.push_back('{"lw0",        32'd0,    MEM_WORD, 1'b0, 1'b1, 32'h12345678});
    vecs.push_back('{"lw3_unal",   32'd3,    MEM_WORD, 1'b0, 1'b1, 32'hFF567812});
    vecs.push_back('{"lw3_sign",   32'd3,    MEM_WORD, 1'b1, 1'b1, 32'hFF567812});
    vecs.push_back('{"lw4",        32'd4,    MEM_WORD, 1'b0, 1'b1, 32'h00FF5678});
    vecs.push_back('{"lh5",        32'd5,    MEM_HALF, 1'b1, 1'b1, 32'hFFFFFF56});
    vecs.push_back('{"lhu5",       32'd5,    MEM_HALF, 1'b0, 1'b1, 32'h0000FF56});
    vecs.push_back('{"lh2",        32'd2,    MEM_HALF, 1'b1, 1'b1, 32'h00001234});
    vecs.push_back('{"lb0",        32'd0,    MEM_BYTE, 1'b1, 1'b1, 32'h00000078});
    vecs.push_back('{"lbu0",       32'd0,    MEM_BYTE, 1'b0, 1'b1, 32'h00000078});
    vecs.push_back('{"lb6",        32'd6,    MEM_BYTE, 1'b1, 1'b1, 32'hFFFFFFFF});
    vecs.push_back('{"lbu6",       32'd6,    MEM_BYTE, 1'b0, 1'b1, 32'h000000FF});
    vecs.push_back('{"read_off",   32'd0,    MEM_WORD, 1'b0, 1'b0, 32'h00000000});
    vecs.push_back('{"size_none",  32'd0,    MEM_NONE, 1'b0, 1'b1, 32'h00000000});
    vecs.push_back('{"alias_1024", 32'd1024, MEM_WORD, 1'b0, 1'b1, 32'h12345678});
    vecs.push_back('{"alias_high", 32'h8000_0003, MEM_WORD, 1'b0, 1'b1, 32'hFF567812});

    foreach (vecs[k])
      load_check(vecs[k].name, vecs[k].a, vecs[k].size, vecs[k].sign, vecs[k].rd, vecs[k].exp);

    store(DEPTH - 2, 32'hAABBCCDD, MEM_WORD);
    load_check("wrap_b_top2", DEPTH - 2, MEM_BYTE, 1'b0, 1'b1, 32'h000000DD);
    load_check("wrap_b_top1", DEPTH - 1, MEM_BYTE, 1'b0, 1'b1, 32'h000000CC);
    load_check("wrap_b_0",    32'd0,     MEM_BYTE, 1'b0, 1'b1, 32'h000000BB);
    load_check("wrap_b_1",    32'd1,     MEM_BYTE, 1'b0, 1'b1, 32'h000000AA);
    load_check("wrap_lw",     DEPTH - 2, MEM_WORD, 1'b0, 1'b1, 32'hAABBCCDD);
    load_check("wrap_lw0",    32'd0,     MEM_WORD, 1'b0, 1'b1, 32'h1234AABB);

    // Read-during-write: old data before the edge, new data right after it.
    @(negedge clk);
    addr = 32'd8; din = 32'hCAFEBABE; memSize = MEM_WORD; memSign = 1'b0;
    memWrite = 1'b1; memRead = 1'b1;
    #1 check("rdw_before", dout, 32'h00000000);
    @(posedge clk);
    #1 check("rdw_after", dout, 32'hCAFEBABE);
    memWrite = 1'b0;

    // Asynchronous reset between edges, with a store pending.
    @(negedge clk);
    addr = 32'd0; memSize = MEM_WORD; memRead = 1'b1; memWrite = 1'b0;
    #1 check("pre_reset", dout, 32'h1234AABB);
    #1 rst = 1'b0;
    addr = 32'd16; din = 32'h11111111; memWrite = 1'b1;
    #1 check("reset_async_dout", dout, 32'h00000000);
    @(posedge clk);
    #1 check("reset_hold_dout", dout, 32'h00000000);
    @(negedge clk);
    memWrite = 1'b0; rst = 1'b1;
    load_check("reset_blocked_store", 32'd16, MEM_WORD, 1'b0, 1'b1, 32'h00000000);
    load_check("reset_cleared_8",     32'd8,  MEM_WORD, 1'b0, 1'b1, 32'h00000000);
    load_check("reset_cleared_top",   DEPTH - 2, MEM_WORD, 1'b0, 1'b1, 32'h00000000);

    iaddr = 32'd0;    #1 check("imem_a0",    idout, 32'h20080005);
    iaddr = 32'd4;    #1 check("imem_a4",    idout, 32'h20090007);
    iaddr = 32'd5;    #1 check("imem_a5",    idout, 32'h20090007);
    iaddr = 32'd8;    #1 check("imem_a8",    idout, 32'h00000000);
    iaddr = 32'd1028; #1 check("imem_wrap",  idout, 32'h20090007);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
